// File: rtl/nvram_upload_reader_pkg.sv
// Shared types and constants for the ioctl upload (RAM read-back) responder.
package nvram_upload_reader_pkg;

  typedef enum logic [1:0] {IDLE, ARB, READ, DONE} state_t;

  localparam logic [7:0] NVRAM_UPLOAD_INDEX = 8'd4;
  localparam logic [7:0] OOR_FILL           = 8'hFF;

endpackage

// File: rtl/nvram_upload_reader.sv
// Answers host ioctl upload reads by fetching one byte per strobe from the
// second port of a shared game RAM, yielding to the CPU while cpu_busy is high.
module nvram_upload_reader
  import nvram_upload_reader_pkg::*;
#(
  parameter logic [7:0] INDEX      = NVRAM_UPLOAD_INDEX,
  parameter int         SIZE       = 256,
  parameter int         AW         = 8,
  parameter int         RD_LATENCY = 1
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  input  logic          cpu_busy,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_dout,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);
  localparam logic [2:0]    LAT       = 3'(RD_LATENCY);

  state_t        state_reg, state_next;
  logic [2:0]    cnt_reg, cnt_next;
  logic [7:0]    din_reg;
  logic          wait_reg;
  logic [AW-1:0] mem_addr_reg;
  logic          mem_rd_reg;
  logic          done_reg;
  logic          oor_reg;

  logic sel, rd_go, in_range, abort;

  assign sel      = ioctl_upload && (ioctl_index == INDEX);
  assign rd_go    = (state_reg == IDLE) && sel && ioctl_rd;
  assign in_range = ioctl_addr < 25'(SIZE);
  assign abort    = (state_reg != IDLE) && !sel;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ARB leaves only once mem_rd has actually been driven for a cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (rd_go) state_next = in_range ? ARB : DONE;
      ARB: begin
        if (mem_rd_reg) begin
          state_next = READ;
          cnt_next   = LAT;
        end
      end
      READ: begin
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      cnt_next   = 3'd0;
    end
  end

  // The arbitration decision for the next cycle is taken at the edge, so
  // mem_rd is a clean registered pulse coinciding with the ARB cycle it issues in.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      din_reg      <= 8'h00;
      wait_reg     <= 1'b0;
      mem_addr_reg <= '0;
      mem_rd_reg   <= 1'b0;
      done_reg     <= 1'b0;
      oor_reg      <= 1'b0;
    end else begin
      mem_rd_reg <= 1'b0;
      done_reg   <= 1'b0;
      if (abort) begin
        wait_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rd_go) begin
              wait_reg <= 1'b1;
              oor_reg  <= !in_range;
              if (in_range) begin
                mem_addr_reg <= ioctl_addr[AW-1:0];
                mem_rd_reg   <= !cpu_busy;
              end
            end
          end
          ARB: if (!mem_rd_reg) mem_rd_reg <= !cpu_busy;
          READ: begin
            if (cnt_reg == 3'd1) begin
              din_reg  <= mem_dout;
              wait_reg <= 1'b0;
              done_reg <= (mem_addr_reg == LAST_ADDR);
            end
          end
          DONE: begin
            wait_reg <= 1'b0;
            if (oor_reg) din_reg <= OOR_FILL;
          end
          default: wait_reg <= 1'b0;
        endcase
      end
    end
  end

  assign ioctl_din  = din_reg;
  assign ioctl_wait = wait_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_rd     = mem_rd_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Scoreboard bench: each read pushes its expected byte/done, a monitor pops on
// every falling edge of ioctl_wait; timing checks are made alongside stimulus.
module tb_nvram_upload_reader;
  import nvram_upload_reader_pkg::*;

  localparam int L = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_upload = 1'b1;
  logic [7:0]  ioctl_index = 8'd4;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        cpu_busy = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_dout;
  logic        done;

  nvram_upload_reader #(.INDEX(8'd4), .SIZE(256), .AW(8), .RD_LATENCY(L)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .cpu_busy(cpu_busy),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout), .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM model: read data appears L cycles after the mem_rd cycle, junk otherwise
  logic [7:0] ram  [0:255];
  logic [7:0] pipe [0:L-1];
  always @(posedge clk_sys) begin
    pipe[0] <= mem_rd ? ram[mem_addr] : 8'hEE;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[L-1];

  typedef struct {
    logic [7:0] din;
    logic       dn;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_count = 0;
  logic [7:0] last_din = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Monitor: a completed (or aborted) access is seen as ioctl_wait falling.
  initial begin
    logic wait_prev;
    exp_t e;
    wait_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (done) done_count++;
      if (wait_prev && !ioctl_wait) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_output: din 0x%0h with empty scoreboard", ioctl_din);
        end else begin
          e = exp_q.pop_front();
          chk("din", int'(ioctl_din), int'(e.din));
          chk("done_at_return", int'(done), int'(e.dn));
        end
      end
      wait_prev = ioctl_wait;
    end
  end

  task automatic do_read(input logic [24:0] addr, input int busy,
                         input logic [7:0] exp_din, input logic exp_done, input bit in_range);
    int wait_cycles, rd_cycle, rd_count;
    logic [7:0] a8;
    a8 = addr[7:0];
    wait_cycles = 0; rd_cycle = -1; rd_count = 0;
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b1; ioctl_addr = addr; cpu_busy = (busy > 0);
    exp_q.push_back('{din: exp_din, dn: exp_done});
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      cpu_busy = (k < busy);
      @(negedge clk_sys);
      if (ioctl_wait) wait_cycles++;
      if (mem_rd) begin
        rd_count++;
        if (rd_cycle < 0) begin
          rd_cycle = k;
          chk("mem_addr", int'(mem_addr), int'(a8));
        end
      end
      if (!ioctl_wait) break;
      @(posedge clk_sys); #1;
    end
    cpu_busy = 1'b0;
    last_din = exp_din;
    if (in_range) begin
      chk("wait_width", wait_cycles, 1 + busy + L);
      chk("mem_rd_cycle", rd_cycle, 1 + busy);
      chk("mem_rd_count", rd_count, 1);
    end else begin
      chk("oor_wait_width", wait_cycles, 1);
      chk("oor_mem_rd_count", rd_count, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_seen, wait_seen;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    ram[8'h10] = 8'h5A;

    // Reset values
    @(negedge clk_sys);
    chk("rst_din", int'(ioctl_din), 0);
    chk("rst_wait", int'(ioctl_wait), 0);
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk_sys); #1 reset_n = 1'b1;
    repeat (2) @(posedge clk_sys);

    do_read(25'h10, 0, 8'h5A, 1'b0, 1'b1);
    ram[8'h10] = 8'h10 ^ 8'hA5;
    do_read(25'h20, 5, 8'h20 ^ 8'hA5, 1'b0, 1'b1);
    do_read(25'h100, 0, OOR_FILL, 1'b0, 1'b0);
    do_read(25'h1000010, 0, OOR_FILL, 1'b0, 1'b0);

    // Abort: upload dropped during the mem_rd cycle
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b1; ioctl_addr = 25'h33;
    exp_q.push_back('{din: last_din, dn: 1'b0});
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b0; ioctl_upload = 1'b0;
    @(negedge clk_sys);
    chk("abort_mem_rd_issued", int'(mem_rd), 1);
    @(negedge clk_sys);
    chk("abort_wait", int'(ioctl_wait), 0);
    chk("abort_mem_rd", int'(mem_rd), 0);
    chk("abort_din_kept", int'(ioctl_din), int'(last_din));
    @(posedge clk_sys); #1 ioctl_upload = 1'b1;
    repeat (L + 2) @(posedge clk_sys);
    do_read(25'h30, 0, 8'h30 ^ 8'hA5, 1'b0, 1'b1);

    // Index mismatch: strobe must be ignored
    @(posedge clk_sys); #1;
    ioctl_index = 8'd0; ioctl_rd = 1'b1; ioctl_addr = 25'h05;
    @(posedge clk_sys); #1 ioctl_rd = 1'b0;
    rd_seen = 0; wait_seen = 0;
    repeat (6) begin
      @(negedge clk_sys);
      if (mem_rd) rd_seen++;
      if (ioctl_wait) wait_seen++;
    end
    chk("idx_mismatch_mem_rd", rd_seen, 0);
    chk("idx_mismatch_wait", wait_seen, 0);
    ioctl_index = 8'd4;

    // Full sweep, done must pulse once on the last byte
    done_count = 0;
    for (int i = 0; i < 256; i++)
      do_read(25'(i), 0, 8'(i) ^ 8'hA5, (i == 255), 1'b1);
    repeat (2) @(posedge clk_sys);
    chk("sweep_done_count", done_count, 1);

    // Asynchronous reset while in READ
    @(posedge clk_sys); #1;
    ioctl_rd = 1'b1; ioctl_addr = 25'h40;
    exp_q.push_back('{din: 8'h00, dn: 1'b0});
    @(posedge clk_sys); #1 ioctl_rd = 1'b0;
    @(posedge clk_sys); #2;
    chk("pre_reset_wait", int'(ioctl_wait), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_wait", int'(ioctl_wait), 0);
    chk("async_rst_din", int'(ioctl_din), 0);
    chk("async_rst_mem_rd", int'(mem_rd), 0);
    repeat (2) @(posedge clk_sys);
    #1 reset_n = 1'b1;
    repeat (L + 2) @(posedge clk_sys);
    do_read(25'h41, 0, 8'h41 ^ 8'hA5, 1'b0, 1'b1);

    repeat (4) @(posedge clk_sys);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nvram_upload_reader.md
Name: nvram_upload_reader

Overview:
- Core-side responder for the ioctl upload direction, complementing the ROM download path that writes through ioctl_wr/ioctl_addr/ioctl_dout.
- On each host read strobe for its ioctl_index, fetches one byte from a shared game RAM (NVRAM / hiscore area) and returns it on ioctl_din.
- Stretches each access with ioctl_wait and yields the RAM port to the game CPU whenever cpu_busy is high.
- Sits beside the game core in the top level, between the host ioctl bus and the RAM's second port.

Parameters:
- INDEX, 8'd4, ioctl_index value this block answers to.
- SIZE, 256, number of readable bytes; valid byte addresses are 0..SIZE-1.
- AW, 8, RAM address width; must satisfy 2**AW >= SIZE.
- RD_LATENCY, 1, cycles from the mem_rd cycle to valid mem_dout; legal range 1..7.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ioctl_upload  in  1  upload session active
- ioctl_index  in  8  selected upload target
- ioctl_rd  in  1  one-cycle read strobe from host
- ioctl_addr  in  25  byte address of the read
- ioctl_din  out  8  returned byte
- ioctl_wait  out  1  high while the read is in progress
- cpu_busy  in  1  game CPU owns the RAM port this cycle
- mem_addr  out  AW  RAM read address
- mem_rd  out  1  RAM read enable, one cycle per access
- mem_dout  in  8  RAM read data
- done  out  1  one-cycle pulse when byte SIZE-1 is returned

Behaviour:
- Reset (async, reset_n=0): state IDLE; ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, done=0, latency counter=0.
- sel = ioctl_upload && (ioctl_index==INDEX). All outputs are registered.
- State IDLE:
  - An ioctl_rd with sel, sampled at edge N, sets ioctl_wait=1 from N+1.
  - If ioctl_addr < SIZE: latch mem_addr=ioctl_addr[AW-1:0] and go to ARB.
  - Otherwise go to DONE with ioctl_din=8'hFF and no RAM access.
- State ARB:
  - If cpu_busy=0: mem_rd=1 for exactly this cycle, load counter=RD_LATENCY, go to READ.
  - If cpu_busy=1: stay in ARB with mem_rd=0; there is no timeout.
- State READ:
  - Decrement the counter each cycle.
  - When the counter reaches 0, capture mem_dout into ioctl_din and go to DONE.
  - cpu_busy is ignored once the read has issued.
- State DONE: ioctl_wait=0 and ioctl_din stays valid; return to IDLE.
  - done pulses in this cycle if the address just served equals SIZE-1.
- Latency, cpu_busy=0 and RD_LATENCY=L:
  - ioctl_rd sampled at N; mem_rd high during N+1; ioctl_din valid and ioctl_wait low from N+2+L.
  - Out-of-range address: ioctl_wait high during N+1 only; 8'hFF valid from N+2.
- Host protocol: the host samples ioctl_wait no earlier than one cycle after its strobe. An ioctl_rd arriving outside IDLE is ignored (no state change).
- sel deasserting in any non-IDLE state aborts the access:
  - next cycle: IDLE, ioctl_wait=0, mem_rd=0, done=0;
  - ioctl_din keeps its previous value;
  - any RAM data still in flight is discarded.
- ioctl_rd with sel=0: no effect. Address comparison uses the full 25-bit ioctl_addr, so no aliasing.
- Reset asserted mid-access: immediate return to the reset values above.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ARB, READ, DONE};
  - constant NVRAM_UPLOAD_INDEX = 8'd4;
  - constant OOR_FILL = 8'hFF.
- No sub-module. The counter and FSM sit in one always block and the output registers in a second.

Test Plan:
- Basic read:
  - Stimulus: RAM[0x10]=8'h5A, RD_LATENCY=1, cpu_busy=0; ioctl_rd at addr 0x10, cycle 0.
  - Required: mem_rd high at cycle 1 with mem_addr=0x10; ioctl_wait high during cycles 1-2; ioctl_din=8'h5A and wait low at cycle 3.
- Arbitration:
  - Stimulus: cpu_busy held high for 5 cycles after the strobe.
  - Required: mem_rd stays low during those cycles; the read issues on the first cycle with cpu_busy low; ioctl_wait widened by exactly 5 cycles.
- Out of range:
  - Stimulus: SIZE=256, ioctl_addr=0x100.
  - Required: mem_rd never asserted; ioctl_din=8'hFF at cycle 2; ioctl_wait high for 1 cycle only.
- Full sweep:
  - Stimulus: RAM[i]=i^8'hA5; read addresses 0..255, RD_LATENCY=3.
  - Required: every byte matches; done pulses exactly once, on addr 255.
- Abort:
  - Stimulus: ioctl_upload dropped in the cycle mem_rd is high.
  - Required: next cycle IDLE with wait=0; ioctl_din unchanged; a following strobe works normally.
- Index mismatch and reset:
  - ioctl_index=8'd0 with ioctl_rd: no mem_rd, no wait.
  - reset_n pulsed low in READ: wait=0 and din=8'h00 immediately, without waiting for a clock.
